mfcc_frame_sequencer: RTL and testbench
=======================================

// Module: mfcc_frame_sequencer
// PURPOSE
//   Frame-level controller for the MFCC front end. Sequences window_buffer -> Hamming_Window -> FFT
//   per 400-sample frame: starts windowing when a frame is assembled, issues the window slide
//   (start_move), hands the windowed frame to the FFT, counts frames and flags stalls/timeouts.
//   Replaces the ad-hoc start_move glue; sits beside the datapath, drives only control strobes.
// PARAMETERS
//   FRAME_CNT_WIDTH  16     width of frame counter and cfg_max_frames_i
//   TIMEOUT_CYCLES   4096   max cycles in any wait state before error; 0 disables watchdog
//   TO_WIDTH         13     watchdog counter width, holds TIMEOUT_CYCLES
// PORTS
//   clk               in   1   system clock
//   rst_n             in   1   async active-low reset
//   enable_i          in   1   level; 1 = run, 0 = stop at next frame boundary
//   cfg_max_frames_i  in   FRAME_CNT_WIDTH  frames to process; 0 = unlimited; sampled on IDLE exit
//   win_frame_rdy_i   in   1   window_buffer start_next_state_o (frame assembled)
//   win_idle_i        in   1   window_buffer in idle state (accepts start_move)
//   ham_start_o       out  1   1-cycle pulse: start Hamming_Window
//   ham_done_i        in   1   Hamming_Window done_o
//   start_move_o      out  1   1-cycle pulse: slide window by MOVE_SIZE
//   fft_ready_i       in   1   FFT can accept a frame
//   fft_start_o       out  1   1-cycle pulse: FFT consumes Hamming frame buffer
//   fft_done_i        in   1   FFT finished reading/processing frame
//   frame_cnt_o       out  FRAME_CNT_WIDTH  frames completed (fft_done seen)
//   busy_o            out  1   state != IDLE/DONE
//   done_o            out  1   level, high in DONE
//   error_o           out  1   sticky watchdog timeout; cleared only by reset
//   state_o           out  3   encoded state, for debug
// BEHAVIOUR
//   Reset: all pulses 0, frame_cnt_o 0, busy_o/done_o/error_o 0, state IDLE, flags cleared.
//   States: IDLE, WAIT_WIN, RUN_HAM, HANDOFF, RUN_FFT, DONE.
//   IDLE: enable_i=1 -> latch cfg_max_frames_i, WAIT_WIN. frame_cnt_o cleared on this exit.
//   WAIT_WIN: win_frame_rdy_i=1 -> ham_start_o pulse next cycle, RUN_HAM (registered, latency 1).
//     enable_i=0 here -> IDLE (clean boundary). win_frame_rdy_i held high counts once.
//   RUN_HAM: ham_done_i=1 -> HANDOFF; clear flags moved/fft_started.
//   HANDOFF: two independent one-shot actions, each flagged once done:
//     - win_idle_i=1 & !moved -> start_move_o pulse, moved<=1.
//     - fft_ready_i=1 & !fft_started -> fft_start_o pulse, fft_started<=1.
//     Both may fire in the same cycle. Both flags set -> RUN_FFT.
//     Last frame (count+1 == max, max!=0): start_move suppressed, moved treated as 1.
//   RUN_FFT: window buffer refills in parallel. fft_done_i=1 -> frame_cnt_o+1;
//     then DONE if max!=0 & new count==max; else WAIT_WIN (IDLE if enable_i=0).
//   DONE: done_o=1; enable_i=0 -> IDLE. Stays in DONE while enable_i=1.
//   Watchdog: counter clears on every state change; increments in WAIT_WIN, RUN_HAM, HANDOFF,
//     RUN_FFT; on reaching TIMEOUT_CYCLES -> error_o<=1, all pulses 0, state IDLE, no restart
//     until enable_i deasserted then reasserted.
//   Every pulse output is exactly 1 cycle; never asserted outside its state.
//   frame_cnt_o saturates at all-ones (no wrap). Stray ham_done_i/fft_done_i in other states ignored.
//   enable_i drop mid-frame does not abort: frame completes through RUN_FFT.
//   Reset mid-operation: immediate return to reset values; downstream blocks reset by same rst_n.
// STRUCTURE
//   mfcc_pkg: seq_state_t enum (3-bit), FRAME_SIZE=400, FRAME_MOVE=160, NFFT=512 constants.
//   Single module, no sub-module; watchdog is an inline counter.
// TESTING
//   T1 reset: rst_n=0 mid-RUN_FFT -> all outputs 0, state_o=IDLE within same cycle (async).
//   T2 max=3, all ready: pulses ham_start x3, start_move x2, fft_start x3; frame_cnt_o=3, done_o=1.
//   T3 fft_ready_i low 50 cycles after ham_done -> start_move_o fires at once, fft_start_o
//     exactly 1 cycle after fft_ready_i rises, state RUN_FFT next.
//   T4 win_idle_i and fft_ready_i rise same cycle in HANDOFF -> both pulses same cycle, one each.
//   T5 TIMEOUT_CYCLES=64, ham_done_i never asserted -> error_o=1 at 64 cycles in RUN_HAM, IDLE.
//   T6 full chain with seno_440Hz.hex, max=0, enable_i dropped after frame 5 -> frame_cnt_o=6, IDLE.

Source files
------------

// File: rtl/mfcc_pkg.sv
// Shared types and frame geometry for the MFCC front-end control path.
package mfcc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_WIN = 3'd1,
      ST_RUN_HAM  = 3'd2,
      ST_HANDOFF  = 3'd3,
      ST_RUN_FFT  = 3'd4,
      ST_DONE     = 3'd5
   } seq_state_t;

   localparam int FRAME_SIZE = 400;
   localparam int FRAME_MOVE = 160;
   localparam int NFFT       = 512;

endpackage

// File: rtl/mfcc_frame_sequencer.sv
// Frame-level sequencer: window_buffer -> Hamming_Window -> FFT, with frame count and watchdog.
// state    | meaning
// IDLE     | stopped, waits for enable_i (and re-arm after a timeout)
// WAIT_WIN | waits for an assembled frame from window_buffer
// RUN_HAM  | Hamming window running
// HANDOFF  | issuing start_move / fft_start one-shots
// RUN_FFT  | FFT consuming frame, window refills in parallel
// DONE     | frame budget reached, holds until enable_i drops
module mfcc_frame_sequencer #(
   parameter int FRAME_CNT_WIDTH = 16,
   parameter int TIMEOUT_CYCLES  = 4096,
   parameter int TO_WIDTH        = 13
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable_i,
   input  logic [FRAME_CNT_WIDTH-1:0] cfg_max_frames_i,
   input  logic                       win_frame_rdy_i,
   input  logic                       win_idle_i,
   output logic                       ham_start_o,
   input  logic                       ham_done_i,
   output logic                       start_move_o,
   input  logic                       fft_ready_i,
   output logic                       fft_start_o,
   input  logic                       fft_done_i,
   output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       error_o,
   output logic [2:0]                 state_o
);
   import mfcc_pkg::*;

   localparam int W = FRAME_CNT_WIDTH;
   localparam logic [TO_WIDTH-1:0] WD_LAST =
      TO_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   seq_state_t          state, state_n;
   logic [W-1:0]        max_q, max_n, cnt_q, cnt_n, cnt_inc;
   logic [TO_WIDTH-1:0] wd_cnt;
   logic                moved, moved_n, started, started_n;
   logic                rdy_used, used_n, wd_block, block_n, err_q, err_n;
   logic                ham_q, ham_n, move_q, move_n, fft_q, fft_n;
   logic                last_frame, wd_active;

   assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + W'(1);
   assign last_frame = (|max_q) && (({1'b0, cnt_q} + (W+1)'(1)) == {1'b0, max_q});
   assign wd_active  = (state == ST_WAIT_WIN) || (state == ST_RUN_HAM) ||
                       (state == ST_HANDOFF)  || (state == ST_RUN_FFT);

   always_comb begin
      state_n   = state;
      max_n     = max_q;
      cnt_n     = cnt_q;
      moved_n   = moved;
      started_n = started;
      used_n    = rdy_used & win_frame_rdy_i;
      block_n   = wd_block;
      err_n     = err_q;
      ham_n     = 1'b0;
      move_n    = 1'b0;
      fft_n     = 1'b0;
      case (state)
         ST_IDLE: begin
            used_n = 1'b0;
            if (!enable_i) begin
               block_n = 1'b0;
            end else if (!wd_block) begin
               max_n   = cfg_max_frames_i;
               cnt_n   = '0;
               state_n = ST_WAIT_WIN;
            end
         end
         ST_WAIT_WIN: begin
            // A level-held frame-ready is consumed once until the window slides.
            if (!enable_i) begin
               state_n = ST_IDLE;
            end else if (win_frame_rdy_i && !rdy_used) begin
               ham_n   = 1'b1;
               used_n  = 1'b1;
               state_n = ST_RUN_HAM;
            end
         end
         ST_RUN_HAM: begin
            if (ham_done_i) begin
               moved_n   = 1'b0;
               started_n = 1'b0;
               state_n   = ST_HANDOFF;
            end
         end
         ST_HANDOFF: begin
            if (last_frame) begin
               moved_n = 1'b1;
            end else if (win_idle_i && !moved) begin
               move_n  = 1'b1;
               moved_n = 1'b1;
               used_n  = 1'b0;
            end
            if (fft_ready_i && !started) begin
               fft_n     = 1'b1;
               started_n = 1'b1;
            end
            if (moved_n && started_n) state_n = ST_RUN_FFT;
         end
         ST_RUN_FFT: begin
            if (fft_done_i) begin
               cnt_n = cnt_inc;
               if ((|max_q) && (cnt_inc == max_q)) state_n = ST_DONE;
               else if (enable_i)                  state_n = ST_WAIT_WIN;
               else                                state_n = ST_IDLE;
            end
         end
         ST_DONE: begin
            if (!enable_i) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
      if ((TIMEOUT_CYCLES != 0) && wd_active && (state_n == state) && (wd_cnt == WD_LAST)) begin
         err_n   = 1'b1;
         block_n = 1'b1;
         state_n = ST_IDLE;
         ham_n   = 1'b0;
         move_n  = 1'b0;
         fft_n   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         max_q    <= '0;
         cnt_q    <= '0;
         wd_cnt   <= '0;
         moved    <= 1'b0;
         started  <= 1'b0;
         rdy_used <= 1'b0;
         wd_block <= 1'b0;
         err_q    <= 1'b0;
         ham_q    <= 1'b0;
         move_q   <= 1'b0;
         fft_q    <= 1'b0;
      end else begin
         state    <= state_n;
         max_q    <= max_n;
         cnt_q    <= cnt_n;
         moved    <= moved_n;
         started  <= started_n;
         rdy_used <= used_n;
         wd_block <= block_n;
         err_q    <= err_n;
         ham_q    <= ham_n;
         move_q   <= move_n;
         fft_q    <= fft_n;
         if ((state_n != state) || !wd_active) wd_cnt <= '0;
         else                                  wd_cnt <= wd_cnt + TO_WIDTH'(1);
      end
   end

   assign ham_start_o  = ham_q;
   assign start_move_o = move_q;
   assign fft_start_o  = fft_q;
   assign frame_cnt_o  = cnt_q;
   assign busy_o       = (state != ST_IDLE) && (state != ST_DONE);
   assign done_o       = (state == ST_DONE);
   assign error_o      = err_q;
   assign state_o      = state;

endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// Scoreboard bench for mfcc_frame_sequencer: directed scenarios with a simple downstream model.
module tb_mfcc_frame_sequencer;

   localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_HAM = 3'd2,
                          S_HOFF = 3'd3, S_FFT = 3'd4, S_DONE = 3'd5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable_i = 1'b0;
   logic [15:0] cfg_max_frames_i = '0;
   logic        win_frame_rdy_i = 1'b1;
   logic        win_idle_i = 1'b1;
   logic        ham_done_i = 1'b0;
   logic        fft_ready_i = 1'b1;
   logic        fft_done_i = 1'b0;
   logic        ham_start_o, start_move_o, fft_start_o;
   logic [15:0] frame_cnt_o;
   logic        busy_o, done_o, error_o;
   logic [2:0]  state_o;

   int checks = 0;
   int failures = 0;
   logic [2:0]  exp_mask[$];
   logic [15:0] exp_cnt[$];
   logic        ham_en = 1'b1;

   mfcc_frame_sequencer #(.FRAME_CNT_WIDTH(16), .TIMEOUT_CYCLES(64), .TO_WIDTH(13)) dut (
      .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .cfg_max_frames_i(cfg_max_frames_i),
      .win_frame_rdy_i(win_frame_rdy_i), .win_idle_i(win_idle_i),
      .ham_start_o(ham_start_o), .ham_done_i(ham_done_i),
      .start_move_o(start_move_o), .fft_ready_i(fft_ready_i),
      .fft_start_o(fft_start_o), .fft_done_i(fft_done_i),
      .frame_cnt_o(frame_cnt_o), .busy_o(busy_o), .done_o(done_o),
      .error_o(error_o), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_ev(input logic [2:0] mask, input logic [15:0] cnt);
      exp_mask.push_back(mask);
      exp_cnt.push_back(cnt);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      int n = 0;
      while (state_o !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(state_o), 32'(s));
   endtask

   // Downstream model: Hamming done 3 cycles after start, FFT done 5 cycles after start.
   initial begin
      int ham_pend = 0;
      int fft_pend = 0;
      forever begin
         @(negedge clk);
         ham_done_i = 1'b0;
         fft_done_i = 1'b0;
         if (ham_pend > 0) begin
            ham_pend--;
            if (ham_pend == 0) ham_done_i = ham_en;
         end
         if (fft_pend > 0) begin
            fft_pend--;
            if (fft_pend == 0) fft_done_i = 1'b1;
         end
         if (ham_start_o) ham_pend = 3;
         if (fft_start_o) fft_pend = 5;
      end
   end

   // Monitor: every cycle with any pulse pops one expected {ham,move,fft} set.
   initial begin
      logic [2:0] m;
      forever begin
         @(negedge clk);
         m = {ham_start_o, start_move_o, fft_start_o};
         if (m != 3'b000) begin
            if (exp_mask.size() == 0) begin
               chk("unexpected_pulse", 32'(m), 32'd0);
            end else begin
               chk("pulse_set", 32'(m), 32'(exp_mask.pop_front()));
               chk("pulse_cnt", 32'(frame_cnt_o), 32'(exp_cnt.pop_front()));
            end
         end
      end
   end

   initial begin
      int hams;
      #3;
      chk("rst_state", 32'(state_o), 32'(S_IDLE));
      chk("rst_outs", 32'({ham_start_o, start_move_o, fft_start_o, busy_o, done_o, error_o}), 32'd0);
      chk("rst_cnt", 32'(frame_cnt_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // T2: three frames, everything ready; last frame has no slide.
      for (int f = 0; f < 3; f++) begin
         expect_ev(3'b100, 16'(f));
         expect_ev((f == 2) ? 3'b001 : 3'b011, 16'(f));
      end
      cfg_max_frames_i = 16'd3;
      enable_i = 1'b1;
      @(negedge clk);
      chk("t2_busy", 32'(busy_o), 32'd1);
      wait_state(S_DONE, 100, "t2_reach_done");
      chk("t2_cnt", 32'(frame_cnt_o), 32'd3);
      chk("t2_done", 32'(done_o), 32'd1);
      repeat (5) @(negedge clk);
      chk("t2_hold_done", 32'(state_o), 32'(S_DONE));
      enable_i = 1'b0;
      wait_state(S_IDLE, 5, "t2_idle");
      chk("t2_not_done", 32'({busy_o, done_o}), 32'd0);

      // T3: FFT not ready for 50 cycles; slide fires immediately, fft_start one cycle after ready.
      expect_ev(3'b100, 16'd0);
      expect_ev(3'b010, 16'd0);
      expect_ev(3'b001, 16'd0);
      cfg_max_frames_i = 16'd0;
      fft_ready_i = 1'b0;
      enable_i = 1'b1;
      wait_state(S_HOFF, 20, "t3_handoff");
      @(negedge clk);
      chk("t3_move_now", 32'(start_move_o), 32'd1);
      repeat (49) @(negedge clk);
      chk("t3_still_handoff", 32'(state_o), 32'(S_HOFF));
      fft_ready_i = 1'b1;
      @(negedge clk);
      chk("t3_fft_start", 32'(fft_start_o), 32'd1);
      chk("t3_run_fft", 32'(state_o), 32'(S_FFT));
      enable_i = 1'b0;
      wait_state(S_IDLE, 20, "t3_idle");
      chk("t3_cnt", 32'(frame_cnt_o), 32'd1);

      // T4: slide and FFT handoff released in the same cycle.
      expect_ev(3'b100, 16'd0);
      expect_ev(3'b011, 16'd0);
      win_idle_i = 1'b0;
      fft_ready_i = 1'b0;
      enable_i = 1'b1;
      wait_state(S_HOFF, 20, "t4_handoff");
      repeat (5) @(negedge clk);
      chk("t4_waiting", 32'({start_move_o, fft_start_o, state_o}), 32'({2'b00, S_HOFF}));
      win_idle_i = 1'b1;
      fft_ready_i = 1'b1;
      @(negedge clk);
      chk("t4_both", 32'({start_move_o, fft_start_o}), 32'd3);
      chk("t4_run_fft", 32'(state_o), 32'(S_FFT));
      @(negedge clk);
      chk("t4_one_each", 32'({start_move_o, fft_start_o}), 32'd0);
      enable_i = 1'b0;
      wait_state(S_IDLE, 20, "t4_idle");

      // T6: unlimited frames, enable dropped during frame 6; frame 6 completes.
      for (int f = 0; f < 6; f++) begin
         expect_ev(3'b100, 16'(f));
         expect_ev(3'b011, 16'(f));
      end
      enable_i = 1'b1;
      hams = 0;
      for (int n = 0; n < 400 && hams < 6; n++) begin
         @(negedge clk);
         if (ham_start_o) hams++;
      end
      chk("t6_sixth_frame", 32'(hams), 32'd6);
      enable_i = 1'b0;
      wait_state(S_IDLE, 50, "t6_idle");
      chk("t6_cnt", 32'(frame_cnt_o), 32'd6);

      // T5: Hamming never finishes -> timeout after 64 cycles in RUN_HAM.
      expect_ev(3'b100, 16'd0);
      ham_en = 1'b0;
      enable_i = 1'b1;
      hams = 0;
      for (int n = 0; n < 20 && hams == 0; n++) begin
         @(negedge clk);
         if (ham_start_o) hams = 1;
      end
      chk("t5_ham_start", 32'(hams), 32'd1);
      repeat (63) @(negedge clk);
      chk("t5_before_to", 32'({error_o, state_o}), 32'({1'b0, S_HAM}));
      @(negedge clk);
      chk("t5_error", 32'(error_o), 32'd1);
      chk("t5_idle", 32'(state_o), 32'(S_IDLE));
      repeat (5) @(negedge clk);
      chk("t5_no_restart", 32'(state_o), 32'(S_IDLE));
      ham_en = 1'b1;
      cfg_max_frames_i = 16'd1;
      expect_ev(3'b100, 16'd0);
      expect_ev(3'b001, 16'd0);
      enable_i = 1'b0;
      @(negedge clk);
      enable_i = 1'b1;
      wait_state(S_DONE, 100, "t5_rearm_done");
      chk("t5_rearm_cnt", 32'(frame_cnt_o), 32'd1);
      chk("t5_sticky", 32'(error_o), 32'd1);
      enable_i = 1'b0;
      wait_state(S_IDLE, 5, "t5_idle2");

      // T1: asynchronous reset in the middle of RUN_FFT.
      expect_ev(3'b100, 16'd0);
      expect_ev(3'b011, 16'd0);
      cfg_max_frames_i = 16'd0;
      enable_i = 1'b1;
      wait_state(S_FFT, 30, "t1_run_fft");
      #2 rst_n = 1'b0;
      #1;
      chk("t1_state", 32'(state_o), 32'(S_IDLE));
      chk("t1_outs", 32'({ham_start_o, start_move_o, fft_start_o, busy_o, done_o, error_o}), 32'd0);
      chk("t1_cnt", 32'(frame_cnt_o), 32'd0);
      enable_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      chk("queue_drained", 32'(exp_mask.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
